accum_hex_display: RTL and testbench

- Downstream stage of the Accumulate datapath; consumes the accumulated binary sum and drives the DE-series active-low seven-segment displays.
- Converts the sum to BCD with a sequential shift-and-add-3 (double-dabble) engine, one bit per clock.
- Encodes each BCD digit to segments and holds the result in registers until the next conversion completes.
- Top level slices seg into HEX0..HEX3.

---
 rtl/accum_hex_display.sv | 154 +++++++++++++++
 tb/tb_accum_hex_display.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/accum_hex_display.sv
// Binary-to-BCD (serial double-dabble) converter driving active-low seven-segment digits.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module accum_hex_display #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic [WIDTH-1:0]      value,
  input  logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7*DIGITS-1:0] SEG_RST = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};
`else
  localparam logic [7*DIGITS-1:0] SEG_RST = {DIGITS{SEG_ZERO}};
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [WIDTH-1:0]    pval_q, pval_d;
  logic                done_q, done_d;
  logic [7*DIGITS-1:0] seg_q, seg_d, seg_enc;
  logic [BW+WIDTH-1:0] shifted;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    shifted = {bcd_adj, sh_q} << 1;
  end

  // Scan from the top digit so blanking stops at the first nonzero digit.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    seg_enc = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seg_enc[7*k +: 7] = enc(bcd_q[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (k != 0 && lead && bcd_q[4*k +: 4] == 4'd0) seg_enc[7*k +: 7] = SEG_BLANK;
      else lead = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    done_d  = 1'b0;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          sh_d    = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shifted[BW+WIDTH-1:WIDTH];
        sh_d  = shifted[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = LOAD;
        if (valid) begin
          pend_d = 1'b1;
          pval_d = value;
        end
      end
      LOAD: begin
        seg_d  = seg_enc;
        done_d = 1'b1;
        pend_d = 1'b0;
        bcd_d  = '0;
        cnt_d  = '0;
        // A fresh strobe on this edge supersedes anything still pending.
        if (valid) begin
          sh_d    = value;
          state_d = SHIFT;
        end else if (pend_q) begin
          sh_d    = pval_q;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      done_q  <= 1'b0;
      seg_q   <= SEG_RST;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_accum_hex_display.sv
// Directed bench for accum_hex_display: default 10-bit instance plus a 14-bit instance.
// Expected displays follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_accum_hex_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  value;
  logic        valid;
  logic        busy, done;
  logic [27:0] seg;
  logic [13:0] value14;
  logic        valid14;
  logic        busy14, done14;
  logic [27:0] seg14;

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  int cnt;

  always #5 clk = ~clk;

  accum_hex_display #(.WIDTH(10), .DIGITS(4)) dut (
    .CLOCK_50(clk), .Reset(rst), .value(value), .valid(valid),
    .busy(busy), .done(done), .seg(seg));

  accum_hex_display #(.WIDTH(14), .DIGITS(4)) dut14 (
    .CLOCK_50(clk), .Reset(rst), .value(value14), .valid(valid14),
    .busy(busy14), .done(done14), .seg(seg14));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: dig = 7'b1000000;
      1: dig = 7'b1111001;
      2: dig = 7'b0100100;
      3: dig = 7'b0110000;
      4: dig = 7'b0011001;
      5: dig = 7'b0010010;
      6: dig = 7'b0000010;
      7: dig = 7'b1111000;
      8: dig = 7'b0000000;
      9: dig = 7'b0010000;
      default: dig = 7'b1111111;
    endcase
  endfunction

  // Expected display for hand-computed digits d3..d0.
  function automatic logic [31:0] exp4(input int d3, input int d2, input int d1, input int d0);
    logic [6:0] s3, s2, s1;
    s3 = dig(d3); s2 = dig(d2); s1 = dig(d1);
`ifdef LEADING_ZERO_BLANK_EN
    if (d3 == 0) s3 = 7'b1111111;
    if (d3 == 0 && d2 == 0) s2 = 7'b1111111;
    if (d3 == 0 && d2 == 0 && d1 == 0) s1 = 7'b1111111;
`endif
    exp4 = {4'b0, s3, s2, s1, dig(d0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [9:0] v);
    value = v; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_done(input bit w14, input int maxc, output int nn);
    nn = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (w14 ? done14 : done) begin
        nn = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) c++;
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; value = '0; valid14 = 1'b0; value14 = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_seg", 32'(seg), exp4(0, 0, 0, 0));
    rst = 1'b0;
    tick();

    start(10'd1023);
    chk("busy_rise", 32'(busy), 32'd1);
    wait_done(1'b0, 20, n);
    chk("lat_1023", 32'(n), 32'd11);
    chk("seg_1023", 32'(seg), 32'b0000_1111001_1000000_0100100_0110000);
    chk("busy_fall", 32'(busy), 32'd0);
    tick();
    chk("done_1cyc", 32'(done), 32'd0);

    start(10'd0);
    wait_done(1'b0, 20, n);
    chk("lat_0", 32'(n), 32'd11);
    chk("seg_0", 32'(seg), exp4(0, 0, 0, 0));

    // 5, then 37 and 99 arrive mid-conversion; 99 must win.
    start(10'd5);
    tick(); tick();
    value = 10'd37; valid = 1'b1; tick(); valid = 1'b0;
    tick(); tick();
    value = 10'd99; valid = 1'b1; tick(); valid = 1'b0;
    wait_done(1'b0, 20, n);
    chk("lat_5", 32'(n), 32'd5);
    chk("seg_5", 32'(seg), exp4(0, 0, 0, 5));
    chk("busy_pend", 32'(busy), 32'd1);
    wait_done(1'b0, 20, n);
    chk("lat_99", 32'(n), 32'd11);
    chk("seg_99", 32'(seg), exp4(0, 0, 9, 9));
    count_done(15, cnt);
    chk("no_extra_done", 32'(cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    start(10'd512);
    wait_done(1'b0, 20, n);
    chk("lat_512", 32'(n), 32'd11);
    chk("seg_512", 32'(seg), exp4(0, 5, 1, 2));
    start(10'd300);
    tick(); tick(); tick(); tick();
    chk("seg_hold", 32'(seg), exp4(0, 5, 1, 2));
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_seg", 32'(seg), exp4(0, 0, 0, 0));
    tick();
    rst = 1'b0;
    count_done(15, cnt);
    chk("abort_nodone", 32'(cnt), 32'd0);
    start(10'd8);
    wait_done(1'b0, 20, n);
    chk("lat_8", 32'(n), 32'd11);
    chk("seg_8", 32'(seg), exp4(0, 0, 0, 8));

    start(10'd7);
    wait_done(1'b0, 20, n);
    chk("seg_7", 32'(seg), exp4(0, 0, 0, 7));
    start(10'd40);
    wait_done(1'b0, 20, n);
    chk("seg_40", 32'(seg), exp4(0, 0, 4, 0));

    value14 = 14'd12345; valid14 = 1'b1;
    tick();
    valid14 = 1'b0;
    chk("busy14", 32'(busy14), 32'd1);
    wait_done(1'b1, 30, n);
    chk("lat_12345", 32'(n), 32'd15);
    chk("seg_12345", 32'(seg14), exp4(2, 3, 4, 5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
